jtag_dbg_mailbox: RTL and testbench



---
 rtl/jtag_dbg_mailbox.sv | 215 +++++++++++++++++++++
 tb/tb_jtag_dbg_mailbox.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_dbg_mailbox.sv
// Purpose : JTAG debug receive mailbox. Captured DR words are pushed into an RX FIFO.
//           The CPU drains the FIFO through a four-register window. A CPU-written TX word is driven back to JTAG.
// Latency : push visible 1 cycle after strobe; rdata registered 1 cycle after ren; irq 1 cycle after state.
// Backpressure: none on the JTAG side. A strobe into a full FIFO is dropped and sets a sticky overflow flag.
//
// Ports
//   clk, rstn           system clock, asynchronous active-low reset
//   dbgreg_in/sel/strobe  captured JTAG word, its IR tag (0 = 0x32, 1 = 0x38), push pulse
//   dbgreg_out          TX word presented to the JTAG side
//   addr/wdata/wen/ren  CPU register window (addr[3:2] selects the register)
//   rdata               registered read data
//   irq                 level interrupt: irq_en & FIFO nonempty

// ---------------------------------------------------------------------------
// Generic FIFO used for the RX path.
// Latency : the head reflects a push on the cycle after the push.
// Backpressure: none. The caller must never push when full unless it pops in the same cycle,
//               and must never pop when empty.
// ---------------------------------------------------------------------------
module jtag_dbg_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage is not reset. Clearing the pointers and count is what discards
    // the contents. The consumer masks the head while count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so the AW-bit pointers wrap naturally.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];

endmodule

// ---------------------------------------------------------------------------
// Mailbox top.
// ---------------------------------------------------------------------------
module jtag_dbg_mailbox #(
    parameter int DEPTH = 8,   // RX entries, power of two in 2..128
    parameter int AW    = 3    // log2(DEPTH)
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] dbgreg_in,
    input  logic        dbgreg_sel,
    input  logic        dbgreg_strobe,
    output logic [31:0] dbgreg_out,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    input  logic        wen,
    input  logic        ren,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_RXTAG  = 2'd2;
    localparam logic [1:0] REG_TXDATA = 2'd3;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [1:0]  reg_sel;
    logic        unused_addr_lsb;

    logic [32:0] head_dat;
    logic [AW:0] count;
    logic        nonempty;
    logic        full;
    logic        push;
    logic        pop;
    logic        ovf_set;
    logic        ovf_clr;

    logic        overflow;
    logic        irq_en;
    logic [31:0] tx_word;
    logic [31:0] status_word;
    logic [31:0] head_word;
    logic [31:0] tag_word;

    // Byte address: only the word index matters.
    assign reg_sel         = addr[3:2];
    assign unused_addr_lsb = ^addr[1:0];

    assign nonempty = (count != '0);
    assign full     = (count == FULL_CNT);

    // A pop only happens when there is a word to take. An RXDATA read on an
    // empty FIFO is a plain empty read, even if a push lands in the same
    // cycle. That new word becomes the head on the following cycle.
    assign pop = ren && (reg_sel == REG_RXDATA) && nonempty;

    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign push    = dbgreg_strobe && (!full || pop);
    assign ovf_set = dbgreg_strobe && full && !pop;
    assign ovf_clr = wen && (reg_sel == REG_STATUS) && wdata[1];

    jtag_dbg_fifo #(
        .W     (33),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_rx_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (push),
        .push_dat ({dbgreg_sel, dbgreg_in}),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (count)
    );

    // Overflow is sticky and W1C. A new overflow in the same cycle as the
    // clear must survive, so set has priority.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq_en  <= 1'b0;
            tx_word <= '0;
        end else if (wen) begin
            if (reg_sel == REG_STATUS) begin
                irq_en <= wdata[16];
            end
            if (reg_sel == REG_TXDATA) begin
                tx_word <= wdata;
            end
        end
    end

    assign dbgreg_out = tx_word;

    // Read views. The FIFO storage is unreset, so mask the head while empty.
    always_comb begin
        status_word              = '0;
        status_word[0]           = nonempty;
        status_word[1]           = overflow;
        status_word[2]           = full;
        status_word[8 +: AW+1]   = count;
        status_word[16]          = irq_en;
    end

    assign head_word = nonempty ? head_dat[31:0] : 32'h0;
    assign tag_word  = {30'h0, nonempty, nonempty & head_dat[32]};

    // Read data is sampled from the state before this cycle's updates. A
    // read that coincides with a write therefore returns the old value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata <= '0;
        end else if (ren) begin
            case (reg_sel)
                REG_STATUS: rdata <= status_word;
                REG_RXDATA: rdata <= head_word;
                REG_RXTAG:  rdata <= tag_word;
                REG_TXDATA: rdata <= tx_word;
                default:    rdata <= '0;
            endcase
        end
    end

    // Registered from current state, so irq trails count/irq_en by one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_en & nonempty;
        end
    end

endmodule

// File: tb/tb_jtag_dbg_mailbox.sv
module tb_jtag_dbg_mailbox;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] dbgreg_in;
    logic        dbgreg_sel;
    logic        dbgreg_strobe;
    logic [31:0] dbgreg_out;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        wen;
    logic        ren;
    logic [31:0] rdata;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    jtag_dbg_mailbox #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .dbgreg_in     (dbgreg_in),
        .dbgreg_sel    (dbgreg_sel),
        .dbgreg_strobe (dbgreg_strobe),
        .dbgreg_out    (dbgreg_out),
        .addr          (addr),
        .wdata         (wdata),
        .wen           (wen),
        .ren           (ren),
        .rdata         (rdata),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [32:0] q[$];
    logic        m_ovf;
    logic        m_irq_en;
    logic [31:0] m_tx;
    logic [31:0] m_rdata;
    logic        m_irq;

    task automatic model_reset();
        q.delete();
        m_ovf    = 1'b0;
        m_irq_en = 1'b0;
        m_tx     = '0;
        m_rdata  = '0;
        m_irq    = 1'b0;
    endtask

    task automatic model_step(input logic stb, input logic [31:0] din, input logic sel,
                              input logic rd, input logic wr, input logic [3:0] a,
                              input logic [31:0] wd);
        int n;
        logic [31:0] s;
        logic [1:0] r;
        n = q.size();
        r = a[3:2];
        m_irq = m_irq_en && (n > 0);
        if (rd) begin
            case (r)
                2'd0: begin
                    s = 32'(n) << 8;
                    s[0]  = (n > 0);
                    s[1]  = m_ovf;
                    s[2]  = (n == DEPTH);
                    s[16] = m_irq_en;
                    m_rdata = s;
                end
                2'd1: m_rdata = (n > 0) ? q[0][31:0] : 32'h0;
                2'd2: m_rdata = (n > 0) ? {30'h0, 1'b1, q[0][32]} : 32'h0;
                default: m_rdata = m_tx;
            endcase
        end
        if (rd && r == 2'd1 && n > 0) void'(q.pop_front());
        if (wr && r == 2'd0) begin
            if (wd[1]) m_ovf = 1'b0;
            m_irq_en = wd[16];
        end
        if (wr && r == 2'd3) m_tx = wd;
        if (stb) begin
            if (q.size() < DEPTH) q.push_back({sel, din});
            else m_ovf = 1'b1;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        check("rdata", rdata, m_rdata);
        check("irq", {31'h0, irq}, {31'h0, m_irq});
        check("dbgreg_out", dbgreg_out, m_tx);
    endtask

    task automatic cycle(input logic stb, input logic [31:0] din, input logic sel,
                         input logic rd, input logic wr, input logic [3:0] a,
                         input logic [31:0] wd);
        @(negedge clk);
        dbgreg_strobe = stb;
        dbgreg_in     = din;
        dbgreg_sel    = sel;
        ren           = rd;
        wen           = wr;
        addr          = a;
        wdata         = wd;
        model_step(stb, din, sel, rd, wr, a, wd);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic push(input logic [31:0] d, input logic s);
        cycle(1'b1, d, s, 1'b0, 1'b0, 4'h0, 32'h0);
    endtask
    task automatic rd(input logic [3:0] a);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, a, 32'h0);
    endtask
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, a, d);
    endtask
    task automatic idle();
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    endtask

    initial begin
        rstn = 1'b0;
        dbgreg_strobe = 1'b0; dbgreg_in = '0; dbgreg_sel = 1'b0;
        ren = 1'b0; wen = 1'b0; addr = '0; wdata = '0;
        model_reset();
        #1;
        check("reset_rdata", rdata, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        check("reset_dbgreg_out", dbgreg_out, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Single tagged push, tag/status/data/status.
        push(32'hDEADBEEF, 1'b1);
        rd(4'h8);  check("t1_rxtag", rdata, 32'h3);
        rd(4'h0);  check("t1_status_cnt1", rdata, 32'h101);
        rd(4'h4);  check("t1_rxdata", rdata, 32'hDEADBEEF);
        rd(4'h0);  check("t1_status_cnt0", rdata, 32'h0);

        // Fill, overflow, drain in order, empty read, W1C.
        for (int i = 1; i <= 9; i++) push(32'(i), 1'b0);
        rd(4'h0);  check("t2_status_full_ovf", rdata, 32'h807);
        for (int i = 1; i <= 8; i++) begin
            rd(4'h4); check("t2_drain", rdata, 32'(i));
        end
        rd(4'h4);  check("t2_empty_read", rdata, 32'h0);
        rd(4'h8);  check("t2_empty_tag", rdata, 32'h0);
        wr(4'h0, 32'h2);
        rd(4'h0);  check("t2_ovf_cleared", rdata, 32'h0);

        // Full FIFO: push and pop together.
        for (int i = 0; i < 8; i++) push(32'h100 + 32'(i), 1'b0);
        cycle(1'b1, 32'hAA, 1'b1, 1'b1, 1'b0, 4'h4, 32'h0);
        check("t3_full_pushpop", rdata, 32'h100);
        rd(4'h0);  check("t3_status", rdata, 32'h805);
        for (int i = 0; i < 8; i++) rd(4'h4);
        check("t3_last", rdata, 32'hAA);

        // Empty FIFO: push and pop together.
        cycle(1'b1, 32'h55, 1'b0, 1'b1, 1'b0, 4'h4, 32'h0);
        check("t4_empty_pushpop", rdata, 32'h0);
        rd(4'h4);  check("t4_next", rdata, 32'h55);

        // Interrupt timing.
        wr(4'h0, 32'h10000);
        push(32'h77, 1'b0);
        check("t5_irq_lag", {31'h0, irq}, 32'h0);
        idle();    check("t5_irq_up", {31'h0, irq}, 32'h1);
        rd(4'h4);  check("t5_irq_hold", {31'h0, irq}, 32'h1);
        idle();    check("t5_irq_down", {31'h0, irq}, 32'h0);

        // TX word, then async reset mid-burst.
        wr(4'hC, 32'h12345678);
        check("t6_tx", dbgreg_out, 32'h12345678);
        push(32'h1, 1'b0); push(32'h2, 1'b1); push(32'h3, 1'b0);
        rd(4'hC);  check("t6_tx_read", rdata, 32'h12345678);
        check("t6_irq_before_rst", {31'h0, irq}, 32'h1);
        @(negedge clk);
        dbgreg_strobe = 1'b1; dbgreg_in = 32'h4;
        #2;
        rstn = 1'b0;
        #1;
        check("t6_rst_dbgreg_out", dbgreg_out, 32'h0);
        check("t6_rst_irq", {31'h0, irq}, 32'h0);
        check("t6_rst_rdata", rdata, 32'h0);
        model_reset();
        dbgreg_strobe = 1'b0; dbgreg_in = '0;
        @(negedge clk);
        rstn = 1'b1;
        rd(4'h0);  check("t6_status_after_rst", rdata, 32'h0);
        rd(4'h4);  check("t6_rxdata_after_rst", rdata, 32'h0);

        // Randomized traffic in phases of differing push/pop pressure.
        for (int ph = 0; ph < 4; ph++) begin
            int p_stb;
            int p_rd;
            p_stb = (ph % 2 == 0) ? 60 : 15;
            p_rd  = (ph % 2 == 0) ? 30 : 70;
            for (int i = 0; i < 600; i++) begin
                logic stb;
                logic rdv;
                logic wrv;
                logic [3:0] a;
                stb = ($urandom_range(0, 99) < p_stb);
                rdv = ($urandom_range(0, 99) < p_rd);
                wrv = ($urandom_range(0, 99) < 10);
                a   = 4'($urandom);
                if (rdv && $urandom_range(0, 1) == 1) a[3:2] = 2'd1;
                cycle(stb, $urandom, 1'($urandom), rdv, wrv, a, $urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
